// File: rtl/row_loader.sv
// Input-side data stager for the matrix unit: captures coefficient set A, then
// double-buffers operand rows and streams one element per ALU-enabled cycle.
module row_loader #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ROW_LEN = 28,
   parameter int unsigned A_WORDS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_A_en,
   input  logic                        load_en,
   input  logic                        alu_en,
   input  logic                        wr_valid,
   input  logic [DATA_W-1:0]           wr_data,
   output logic                        wr_ready,
   output logic                        load_A_done,
   output logic                        load_done,
   output logic [A_WORDS*DATA_W-1:0]   a_coef,
   output logic [DATA_W-1:0]           alu_data,
   output logic                        alu_data_valid,
   output logic                        underrun
);

   localparam int unsigned IDX_W   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int unsigned A_IDX_W = (A_WORDS > 1) ? $clog2(A_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_A, S_ROW, S_FULL} state_t;

   state_t              state;
   state_t              next_state;

   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    rd_idx;
   logic                stage_full;
   logic                work_valid;
   logic [DATA_W-1:0]   coef  [A_WORDS];
   logic [DATA_W-1:0]   stage [ROW_LEN];
   logic [DATA_W-1:0]   work  [ROW_LEN];

   logic                a_fire;
   logic                a_last;
   logic                row_fire;
   logic                row_last;
   logic                rd_last;
   logic                abort;
   logic                transfer;
   logic                consume;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (load_A_en)    next_state = S_A;
            else if (load_en) next_state = S_ROW;
         end
         S_A: begin
            if (!load_A_en)            next_state = S_IDLE;
            else if (a_fire && a_last) next_state = S_ROW;
         end
         S_ROW: begin
            if (!load_en)                  next_state = S_IDLE;
            else if (row_fire && row_last) next_state = S_FULL;
         end
         S_FULL: begin
            if (!load_en)         next_state = S_IDLE;
            else if (!stage_full) next_state = S_ROW;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Decoded handshakes and buffer events; abort outranks everything else
   always_comb begin
      wr_ready = (state == S_A) || (state == S_ROW);
      abort    = ((state == S_ROW) || (state == S_FULL)) && !load_en;
      a_fire   = (state == S_A) && load_A_en && wr_valid;
      row_fire = (state == S_ROW) && load_en && wr_valid;
      a_last   = (wr_idx == IDX_W'(A_WORDS - 1));
      row_last = (wr_idx == IDX_W'(ROW_LEN - 1));
      rd_last  = (rd_idx == IDX_W'(ROW_LEN - 1));
      consume  = alu_en && work_valid;
      transfer = stage_full && !abort && (!work_valid || (alu_en && rd_last));
   end

   // Datapath: coefficient capture, stage fill, stage->work hand-off, read pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx      <= '0;
         rd_idx      <= '0;
         stage_full  <= 1'b0;
         work_valid  <= 1'b0;
         underrun    <= 1'b0;
         load_A_done <= 1'b0;
         load_done   <= 1'b0;
         for (int i = 0; i < int'(A_WORDS); i++) coef[i] <= '0;
         for (int i = 0; i < int'(ROW_LEN); i++) begin
            stage[i] <= '0;
            work[i]  <= '0;
         end
      end else begin
         load_A_done <= a_fire && a_last;
         load_done   <= row_fire && row_last;
         if (alu_en && !work_valid) underrun <= 1'b1;

         if (abort) begin
            stage_full <= 1'b0;
            work_valid <= 1'b0;
            rd_idx     <= '0;
            wr_idx     <= '0;
         end else begin
            if (state == S_IDLE) wr_idx <= '0;

            if (a_fire) begin
               coef[wr_idx[A_IDX_W-1:0]] <= wr_data;
               wr_idx <= a_last ? '0 : wr_idx + IDX_W'(1);
            end

            if (row_fire) begin
               stage[wr_idx] <= wr_data;
               if (row_last) begin
                  wr_idx     <= '0;
                  stage_full <= 1'b1;
               end else begin
                  wr_idx <= wr_idx + IDX_W'(1);
               end
            end

            // Hand-off on the last consumed element keeps the stream gap-free
            if (transfer) begin
               work       <= stage;
               work_valid <= 1'b1;
               rd_idx     <= '0;
               stage_full <= 1'b0;
            end else if (consume) begin
               if (rd_last) begin
                  work_valid <= 1'b0;
                  rd_idx     <= '0;
               end else begin
                  rd_idx <= rd_idx + IDX_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      a_coef = '0;
      for (int i = 0; i < int'(A_WORDS); i++) a_coef[i*DATA_W +: DATA_W] = coef[i];
   end

   assign alu_data       = work[rd_idx];
   assign alu_data_valid = work_valid;

endmodule

// File: tb/tb_row_loader.sv
// Directed self-checking bench for row_loader: coefficient load, two-row fill,
// backpressure, gap-free streaming, underrun, abort and asynchronous reset.
module tb_row_loader;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ROW_LEN = 28;
   localparam int unsigned A_WORDS = 4;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       load_A_en;
   logic                       load_en;
   logic                       alu_en;
   logic                       wr_valid;
   logic [DATA_W-1:0]          wr_data;
   logic                       wr_ready;
   logic                       load_A_done;
   logic                       load_done;
   logic [A_WORDS*DATA_W-1:0]  a_coef;
   logic [DATA_W-1:0]          alu_data;
   logic                       alu_data_valid;
   logic                       underrun;

   int checks = 0;
   int errors = 0;

   row_loader #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .A_WORDS(A_WORDS)) dut (
      .clk            (clk),
      .rst            (rst),
      .load_A_en      (load_A_en),
      .load_en        (load_en),
      .alu_en         (alu_en),
      .wr_valid       (wr_valid),
      .wr_data        (wr_data),
      .wr_ready       (wr_ready),
      .load_A_done    (load_A_done),
      .load_done      (load_done),
      .a_coef         (a_coef),
      .alu_data       (alu_data),
      .alu_data_valid (alu_data_valid),
      .underrun       (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DATA_W-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_ready"},  64'(wr_ready),       64'd0);
      check({tag, "_a_done"},    64'(load_A_done),    64'd0);
      check({tag, "_done"},      64'(load_done),      64'd0);
      check({tag, "_a_coef"},    64'(a_coef),         64'd0);
      check({tag, "_alu_data"},  64'(alu_data),       64'd0);
      check({tag, "_valid"},     64'(alu_data_valid), 64'd0);
      check({tag, "_underrun"},  64'(underrun),       64'd0);
   endtask

   initial begin
      int exp_d;
      rst = 1'b1; load_A_en = 1'b0; load_en = 1'b0; alu_en = 1'b0;
      wr_valid = 1'b0; wr_data = '0;
      tick(); tick();
      check_all_zero("rst");
      rst = 1'b0;
      tick();
      check("idle_wr_ready", 64'(wr_ready), 64'd0);

      // Coefficient load
      load_A_en = 1'b1; load_en = 1'b1;
      tick();
      check("sa_wr_ready", 64'(wr_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         write_word(DATA_W'(8'h11 * (i + 1)));
         if (i < 3) check("a_done_early", 64'(load_A_done), 64'd0);
      end
      check("a_done_pulse", 64'(load_A_done), 64'd1);
      check("a_coef", 64'(a_coef), 64'h44332211);
      check("srow_wr_ready", 64'(wr_ready), 64'd1);
      wr_valid = 1'b0; load_A_en = 1'b0;
      tick();
      check("a_done_clear", 64'(load_A_done), 64'd0);

      // First row: fills stage then moves straight to working
      for (int i = 0; i < 28; i++) begin
         write_word(DATA_W'(i));
         if (i < 27) check("row1_done_early", 64'(load_done), 64'd0);
      end
      check("row1_done", 64'(load_done), 64'd1);
      check("row1_full_ready", 64'(wr_ready), 64'd0);
      check("row1_valid_pre", 64'(alu_data_valid), 64'd0);
      wr_valid = 1'b0;
      tick();
      check("row1_done_clear", 64'(load_done), 64'd0);
      check("row1_valid", 64'(alu_data_valid), 64'd1);
      check("row1_data0", 64'(alu_data), 64'd0);
      check("row1_ready_still0", 64'(wr_ready), 64'd0);
      tick();
      check("row2_ready", 64'(wr_ready), 64'd1);

      // Second row stays in stage
      for (int i = 0; i < 28; i++) write_word(DATA_W'(100 + i));
      check("row2_done", 64'(load_done), 64'd1);
      check("row2_full_ready", 64'(wr_ready), 64'd0);

      // Backpressure: stage full, ALU idle
      wr_data = 8'hEE;
      wr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_wr_ready", 64'(wr_ready), 64'd0);
         check("bp_done", 64'(load_done), 64'd0);
      end
      wr_valid = 1'b0;
      check("bp_data_hold", 64'(alu_data), 64'd0);

      // Streaming 56 elements without a gap
      alu_en = 1'b1;
      for (int i = 0; i < 56; i++) begin
         exp_d = (i < 28) ? i : 100 + i - 28;
         check("stream_valid", 64'(alu_data_valid), 64'd1);
         check("stream_data", 64'(alu_data), 64'(exp_d));
         if (i == 28) check("stream_ready_lag", 64'(wr_ready), 64'd0);
         if (i == 29) check("stream_ready_rise", 64'(wr_ready), 64'd1);
         tick();
      end
      check("stream_end_valid", 64'(alu_data_valid), 64'd0);
      check("stream_no_underrun", 64'(underrun), 64'd0);
      alu_en = 1'b0;

      // Underrun is sticky
      tick();
      check("underrun_pre", 64'(underrun), 64'd0);
      alu_en = 1'b1;
      tick();
      check("underrun_set", 64'(underrun), 64'd1);
      alu_en = 1'b0;
      tick();
      check("underrun_sticky", 64'(underrun), 64'd1);

      // Abort part-way through a row
      for (int i = 0; i < 5; i++) write_word(DATA_W'(8'h50 + i));
      wr_valid = 1'b0; load_en = 1'b0;
      tick();
      check("abort_ready", 64'(wr_ready), 64'd0);
      check("abort_valid", 64'(alu_data_valid), 64'd0);
      check("abort_done", 64'(load_done), 64'd0);
      load_en = 1'b1;
      tick();
      check("reload_ready", 64'(wr_ready), 64'd1);
      for (int i = 0; i < 28; i++) begin
         write_word(DATA_W'(8'h60 + i));
         if (i < 27) check("row3_done_early", 64'(load_done), 64'd0);
      end
      check("row3_done", 64'(load_done), 64'd1);
      wr_valid = 1'b0;
      tick();
      check("row3_valid", 64'(alu_data_valid), 64'd1);
      check("row3_data0", 64'(alu_data), 64'h60);
      check("row3_underrun_kept", 64'(underrun), 64'd1);
      check("row3_coef_kept", 64'(a_coef), 64'h44332211);
      alu_en = 1'b1;
      tick();
      check("row3_data1", 64'(alu_data), 64'h61);
      tick();
      check("row3_data2", 64'(alu_data), 64'h62);

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("arst");
      @(posedge clk);
      #1;
      rst = 1'b0; alu_en = 1'b0; load_en = 1'b0;
      tick();
      check("post_rst_ready", 64'(wr_ready), 64'd0);
      check("post_rst_valid", 64'(alu_data_valid), 64'd0);
      load_A_en = 1'b1; load_en = 1'b1;
      tick();
      check("resume_ready", 64'(wr_ready), 64'd1);
      for (int i = 0; i < 4; i++) write_word(DATA_W'(8'hA1 + i));
      check("resume_a_done", 64'(load_A_done), 64'd1);
      check("resume_a_coef", 64'(a_coef), 64'hA4A3A2A1);
      wr_valid = 1'b0; load_A_en = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
